button_counter: RTL

BUTTON_COUNTER -- requirements
Module: button_counter

---
 rtl/button_counter_pkg.sv | 14 +
 rtl/button_counter_debouncer.sv | 84 ++++++++
 rtl/button_counter.sv | 65 ++++++
 3 files changed

// File: rtl/button_counter_pkg.sv
// rtl/button_counter_pkg.sv - shared state encoding and sizing constants for button_counter
package button_counter_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    WAIT_PRESS   = 2'd1,
    PRESSED      = 2'd2,
    WAIT_RELEASE = 2'd3
  } db_state_e;

  localparam int DEFAULT_N = 20;
  localparam int COUNT_W   = 8;

endpackage

// File: rtl/button_counter_debouncer.sv
// rtl/button_counter_debouncer.sv - 2-flop synchronizer plus debounce FSM; emits one pulse per accepted press
module button_counter_debouncer
  import button_counter_pkg::*;
#(
  parameter int N = DEFAULT_N
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic pulse
);

  localparam logic [N-1:0] TIMER_MAX = {N{1'b1}};

  logic [1:0]   sync_q, sync_d;
  db_state_e    state_q, state_d;
  logic [N-1:0] timer_q, timer_d;
  logic         pulse_q, pulse_d;
  logic         s;

  assign s     = sync_q[1];
  assign pulse = pulse_q;

  always_comb begin
    sync_d  = {sync_q[0], btn};
    state_d = state_q;
    timer_d = timer_q;
    pulse_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (s) begin
          state_d = WAIT_PRESS;
          timer_d = '0;
        end
      end
      WAIT_PRESS: begin
        if (!s) begin
          state_d = IDLE;
          timer_d = '0;
        end else if (timer_q == TIMER_MAX) begin
          state_d = PRESSED;
          pulse_d = 1'b1;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      PRESSED: begin
        state_d = WAIT_RELEASE;
        timer_d = '0;
      end
      WAIT_RELEASE: begin
        // Any high sample during release restarts the window, so bounce cannot re-arm the press.
        if (s) begin
          timer_d = '0;
        end else if (timer_q == TIMER_MAX) begin
          state_d = IDLE;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        timer_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      state_q <= IDLE;
      timer_q <= '0;
      pulse_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      timer_q <= timer_d;
      pulse_q <= pulse_d;
    end
  end

endmodule

// File: rtl/button_counter.sv
// rtl/button_counter.sv - debounced 8-bit up (and optional down) counter on LEDs; BUTTON_COUNTER_DOWN_EN enables SW2
module button_counter
  import button_counter_pkg::*;
#(
  parameter int N = DEFAULT_N
) (
  input  logic CLK,
  input  logic RSTN,
  input  logic SW1,
  input  logic SW2,
  output logic LED0,
  output logic LED1,
  output logic LED2,
  output logic LED3,
  output logic LED4,
  output logic LED5,
  output logic LED6,
  output logic LED7
);

  logic [COUNT_W-1:0] count_q, count_d;
  logic               up_pulse;
  logic               dn_pulse;

  button_counter_debouncer #(.N(N)) u_db_up (
    .clk   (CLK),
    .rst_n (RSTN),
    .btn   (SW1),
    .pulse (up_pulse)
  );

`ifdef BUTTON_COUNTER_DOWN_EN
  button_counter_debouncer #(.N(N)) u_db_dn (
    .clk   (CLK),
    .rst_n (RSTN),
    .btn   (SW2),
    .pulse (dn_pulse)
  );
`else
  logic unused_sw2;
  assign unused_sw2 = SW2;
  assign dn_pulse   = 1'b0;
`endif

  // Coincident up and down pulses cancel out.
  always_comb begin
    count_d = count_q;
    case ({up_pulse, dn_pulse})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign {LED7, LED6, LED5, LED4, LED3, LED2, LED1, LED0} = count_q;

endmodule
